// File: rtl/pulse_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pulse_cmd_pkg
// Shared pulse command word layout and opcodes (pulse_cmd_queue, pulse_gen).
// Revision : 1.0
// ============================================================================
package pulse_cmd_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [7:0] {
    CMD_RESET_CLOCK = 8'd0,
    CMD_SEND_PULSE  = 8'd1,
    CMD_SET_PERIOD  = 8'd2
  } cmd_e;

  localparam int COMMAND_MSB = 31;
  localparam int COMMAND_LSB = 24;
  localparam int COARSE_MSB  = 23;
  localparam int COARSE_LSB  = 8;
  localparam int FINE_MSB    = 7;
  localparam int FINE_LSB    = 0;
  localparam int PERIOD_MSB  = 23;
  localparam int PERIOD_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// First-word-fall-through FIFO, ADDR_W+1 bit wrapping pointers.
// Revision : 1.0
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_full_level = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_rd_fire;

  assign level     = r_wr_ptr - r_rd_ptr;
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (level == c_full_level);
  assign rd_data   = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_rd_fire = rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full, a write alongside a pop lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/pulse_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : pulse_cmd_queue
// Packs host bytes MSB-first into 32-bit pulse commands queued for pulse_gen.
// Revision : 1.0
// ============================================================================
module pulse_cmd_queue
  import pulse_cmd_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              err_clr,
  output logic              fifo_empty,
  output logic [31:0]       fifo_data,
  input  logic              fifo_read,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              frame_err
);

  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [1:0]         r_byte_idx;
  logic [BYTE_W-1:0]  r_lane0;
  logic [BYTE_W-1:0]  r_lane1;
  logic [BYTE_W-1:0]  r_lane2;
  logic [c_cnt_w-1:0] r_idle_cnt;
  logic               r_overflow;
  logic               r_frame_err;

  logic               w_byte;
  logic               w_last_byte;
  logic               w_pop;
  logic               w_full;
  logic               w_accept;
  logic               w_wr_en;
  logic               w_drop;
  logic               w_timeout;
  logic [WORD_W-1:0]  w_word;

  assign w_byte      = in_valid && !flush;
  assign w_last_byte = w_byte && (r_byte_idx == 2'd3);
  assign w_pop       = fifo_read && !fifo_empty && !flush;
  assign w_accept    = !w_full || w_pop;
  assign w_wr_en     = w_last_byte && w_accept;
  assign w_drop      = w_last_byte && !w_accept;
  assign w_word      = {r_lane0, r_lane1, r_lane2, in_data};
  // The in_valid term keeps a byte landing on the deadline from being discarded.
  assign w_timeout   = !flush && !in_valid && (r_byte_idx != 2'd0) &&
                       (r_idle_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_idx <= 2'd0;
      r_idle_cnt <= '0;
    end else if (flush || w_timeout) begin
      r_byte_idx <= 2'd0;
      r_idle_cnt <= '0;
    end else if (in_valid) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      r_idle_cnt <= '0;
    end else if (r_byte_idx == 2'd0) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_byte) begin
      case (r_byte_idx)
        2'd0:    r_lane0 <= in_data;
        2'd1:    r_lane1 <= in_data;
        2'd2:    r_lane2 <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)       r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_timeout)    r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

  sync_fifo_fwft #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (w_wr_en),
    .wr_data (w_word),
    .rd_en   (w_pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (w_full),
    .level   (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_pulse_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_cmd_queue
// Scoreboard bench for pulse_cmd_queue (ADDR_W=4, TIMEOUT_CYC=16).
// Revision : 1.0
// ============================================================================
module tb_pulse_cmd_queue;

  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic              fifo_empty;
  logic [31:0]       fifo_data;
  logic              fifo_read = 1'b0;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              frame_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  pulse_cmd_queue #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .err_clr    (err_clr),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .level      (level),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: every pop the DUT will perform at the next edge is scored.
  always @(negedge clk) begin
    if (rst && fifo_read && !fifo_empty && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %h, nothing expected", fifo_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (fifo_data !== exp_word) begin
          n_err++;
          $display("FAIL pop_data: got %h, expected %h", fifo_data, exp_word);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic rd);
    in_valid  = v;
    in_data   = d;
    fifo_read = rd;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    fifo_read = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic push, input logic rd_last);
    for (int b = 0; b < 4; b++) begin
      if (b == 3 && push) exp_q.push_back(w);
      cycle(1'b1, w[31-8*b -: 8], (b == 3) ? rd_last : 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    fifo_read = 1'b1;
    while (!fifo_empty && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    fifo_read = 1'b0;
    chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    send_word(32'h01001005, 1'b1, 1'b0);
    chk("single_empty", {31'd0, fifo_empty}, 32'd0);
    chk("single_level", {27'd0, level}, 32'd1);
    chk("single_data", fifo_data, 32'h01001005);
    cycle(1'b0, 8'h00, 1'b1);
    chk("single_pop_empty", {31'd0, fifo_empty}, 32'd1);
    chk("single_pop_level", {27'd0, level}, 32'd0);

    // Overflow: 17 words, only the first 16 kept
    for (int i = 0; i < 17; i++) begin
      w = {8'h01, 8'(i), 8'hA0, 8'(i + 8'h30)};
      send_word(w, (i < 16), 1'b0);
    end
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Write while full with a pop in the same cycle
    send_word(32'h02123456, 1'b1, 1'b1);
    chk("wwf_level", {27'd0, level}, 32'd16);
    chk("wwf_overflow", {31'd0, overflow}, 32'd0);
    drain();

    // Timeout resync
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      @(posedge clk);
      #1;
      if (k == TIMEOUT_CYC - 1) chk("to_early", {31'd0, frame_err}, 32'd0);
      if (k == TIMEOUT_CYC)     chk("to_set", {31'd0, frame_err}, 32'd1);
    end
    send_word(32'h02000064, 1'b1, 1'b0);
    chk("to_resync_data", fifo_data, 32'h02000064);
    drain();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("to_clr", {31'd0, frame_err}, 32'd0);

    // Wrap-around with random reads
    for (int i = 0; i < 40; i++) begin
      w = {8'h01, 8'(i * 3), 8'h5C, 8'(i)};
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back(w);
        cycle(1'b1, w[31-8*b -: 8], 1'($urandom_range(0, 1)));
      end
    end
    drain();
    cycle(1'b0, 8'h00, 1'b1);
    chk("empty_rd_level", {27'd0, level}, 32'd0);
    chk("empty_rd_flags", {30'd0, overflow, frame_err}, 32'd0);

    // Flush with queued words and a partial word
    for (int i = 0; i < 3; i++) send_word({8'h01, 8'(i), 8'h77, 8'h00}, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b1, 8'hDD, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_level", {27'd0, level}, 32'd0);
    chk("flush_empty", {31'd0, fifo_empty}, 32'd1);
    send_word(32'h0100C803, 1'b1, 1'b0);
    chk("flush_clean_level", {27'd0, level}, 32'd1);
    drain();

    // Asynchronous reset mid-byte
    send_word(32'h01ABCDEF, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("arst_level", {27'd0, level}, 32'd0);
    chk("arst_flags", {30'd0, overflow, frame_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    send_word(32'h00000000, 1'b1, 1'b0);
    send_word(32'h02FEDCBA, 1'b1, 1'b0);
    chk("arst_level2", {27'd0, level}, 32'd2);
    drain();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
